// File: rtl/dds_btn_controller.sv
// DDS front-panel controller: button sync, edge detect, arbitration,
// lockout debounce, hold-to-repeat and waveform/FTW/step registers.
module dds_btn_controller #(
    parameter int unsigned      LOCKOUT_CYC = 1_000_000,
    parameter int unsigned      REPEAT_DLY  = 25_000_000,
    parameter int unsigned      REPEAT_PER  = 5_000_000,
    parameter int               FTW_W       = 32,
    parameter logic [FTW_W-1:0] FTW_STEP    = FTW_W'(1),
    parameter logic [FTW_W-1:0] FTW_MIN     = '0,
    parameter logic [FTW_W-1:0] FTW_MAX     = {1'b0, {(FTW_W-1){1'b1}}},
    parameter logic [FTW_W-1:0] FTW_RST     = FTW_W'(1024)
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic [3:0]       iBtnN,
    output logic [1:0]       oWave,
    output logic [FTW_W-1:0] oFtw,
    output logic [1:0]       oStepSel,
    output logic             oCfgValid,
    output logic             oBusy
);
    localparam int XW = FTW_W + 4;
    localparam logic [XW-1:0] MAX_X = {4'b0, FTW_MAX};
    localparam logic [XW-1:0] MIN_X = {4'b0, FTW_MIN};
    localparam logic [31:0] LOCK_LD = 32'(LOCKOUT_CYC - 1);
    localparam logic [31:0] DLY_LD  = 32'(REPEAT_DLY - 1);
    localparam logic [31:0] PER_LD  = 32'(REPEAT_PER - 1);

    typedef enum logic [2:0] {
        IDLE, LOCK, HOLD, REPEAT, WAITREL
    } state_t;

    logic [3:0]    s1, s2, s3, press;
    state_t        state, state_nxt;
    logic [1:0]    g, g_nxt;
    logic [31:0]   cnt, cnt_nxt;
    logic          act, held;
    logic [XW-1:0] step, ftw_x, sum, floor_x;

    assign press   = s3 & ~s2;
    assign step    = {4'b0, FTW_STEP} << {oStepSel, 2'b00};
    assign ftw_x   = {4'b0, oFtw};
    assign sum     = ftw_x + step;
    assign floor_x = step + MIN_X;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            s1 <= 4'hF;
            s2 <= 4'hF;
            s3 <= 4'hF;
        end else begin
            s1 <= iBtnN;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= IDLE;
            g     <= 2'd0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        cnt_nxt   = cnt;
        act       = 1'b0;
        held      = ~s2[g];
        unique case (state)
            IDLE: begin
                if (|press) begin
                    act       = 1'b1;
                    state_nxt = LOCK;
                    cnt_nxt   = LOCK_LD;
                    // lowest index wins; other edges this cycle are dropped
                    priority case (1'b1)
                        press[0]: g_nxt = 2'd0;
                        press[1]: g_nxt = 2'd1;
                        press[2]: g_nxt = 2'd2;
                        default:  g_nxt = 2'd3;
                    endcase
                end
            end
            LOCK: begin
                if (cnt == '0) begin
                    if (!held)
                        state_nxt = IDLE;
                    else if (g == 2'd1 || g == 2'd2) begin
                        state_nxt = HOLD;
                        cnt_nxt   = DLY_LD;
                    end else
                        state_nxt = WAITREL;
                end else
                    cnt_nxt = cnt - 32'd1;
            end
            HOLD, REPEAT: begin
                if (!held)
                    state_nxt = IDLE;
                else if (cnt == '0) begin
                    act       = 1'b1;
                    state_nxt = REPEAT;
                    cnt_nxt   = PER_LD;
                end else
                    cnt_nxt = cnt - 32'd1;
            end
            WAITREL: begin
                if (!held)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            oWave     <= 2'd0;
            oFtw      <= FTW_RST;
            oStepSel  <= 2'd0;
            oCfgValid <= 1'b0;
            oBusy     <= 1'b0;
        end else begin
            oCfgValid <= act;
            oBusy     <= (state_nxt != IDLE);
            if (act) begin
                unique case (g_nxt)
                    2'd0: oWave <= oWave + 2'd1;
                    2'd1: oFtw  <= (sum > MAX_X) ? FTW_MAX
                                                 : FTW_W'(sum);
                    2'd2: oFtw  <= (ftw_x < floor_x) ? FTW_MIN
                                                     : FTW_W'(ftw_x - step);
                    2'd3: oStepSel <= oStepSel + 2'd1;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dds_btn_controller.sv
// Scoreboard bench for dds_btn_controller: directed presses push expected
// config updates; a negedge monitor pops them on every oCfgValid pulse.
module tb_dds_btn_controller;
    logic       CLK = 1'b0;
    logic       RESETn;
    logic [3:0] iBtnN;
    logic [1:0] oWave;
    logic [7:0] oFtw;
    logic [1:0] oStepSel;
    logic       oCfgValid;
    logic       oBusy;

    dds_btn_controller #(
        .LOCKOUT_CYC(4),
        .REPEAT_DLY (10),
        .REPEAT_PER (3),
        .FTW_W      (8),
        .FTW_STEP   (8'd1),
        .FTW_MIN    (8'd0),
        .FTW_MAX    (8'd200),
        .FTW_RST    (8'd100)
    ) dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .iBtnN    (iBtnN),
        .oWave    (oWave),
        .oFtw     (oFtw),
        .oStepSel (oStepSel),
        .oCfgValid(oCfgValid),
        .oBusy    (oBusy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         at;
        logic [1:0] wave;
        int         ftw;
        logic [1:0] sel;
    } exp_t;

    exp_t q[$];

    logic [1:0] m_wave, m_sel;
    int         m_ftw;

    always @(negedge CLK) begin
        exp_t e;
        while (q.size() > 0 && q[0].at < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL cfg_missing: no pulse at cycle %0d, required wave=%0d ftw=%0d sel=%0d",
                     e.at, e.wave, e.ftw, e.sel);
        end
        if (RESETn === 1'b1 && oCfgValid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL cfg_unexpected: pulse at cycle %0d wave=%0d ftw=%0d sel=%0d, required none",
                         cyc, oWave, oFtw, oStepSel);
            end else begin
                e = q.pop_front();
                if (e.at != cyc || e.wave !== oWave || e.ftw != int'(oFtw)
                    || e.sel !== oStepSel) begin
                    errors++;
                    $display("FAIL cfg: got cyc=%0d wave=%0d ftw=%0d sel=%0d, required cyc=%0d wave=%0d ftw=%0d sel=%0d",
                             cyc, oWave, oFtw, oStepSel, e.at, e.wave, e.ftw, e.sel);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    function automatic void apply(input int b);
        int step;
        step = 1 << (4 * int'(m_sel));
        case (b)
            0: m_wave = m_wave + 2'd1;
            1: m_ftw = (m_ftw + step > 200) ? 200 : m_ftw + step;
            2: m_ftw = (m_ftw < step) ? 0 : m_ftw - step;
            default: m_sel = m_sel + 2'd1;
        endcase
    endfunction

    function automatic void expect_at(input int at);
        exp_t e;
        e.at   = at;
        e.wave = m_wave;
        e.ftw  = m_ftw;
        e.sel  = m_sel;
        q.push_back(e);
    endfunction

    function automatic void model_reset();
        m_wave = 2'd0;
        m_ftw  = 100;
        m_sel  = 2'd0;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_wave"}, int'(oWave), 0);
        chk({tag, "_ftw"}, int'(oFtw), 100);
        chk({tag, "_sel"}, int'(oStepSel), 0);
        chk({tag, "_valid"}, int'(oCfgValid), 0);
        chk({tag, "_busy"}, int'(oBusy), 0);
    endtask

    task automatic press(input int b);
        int c;
        c = cyc;
        iBtnN[b] = 1'b0;
        apply(b);
        expect_at(c + 3);
        tick(2);
        iBtnN[b] = 1'b1;
        tick(10);
    endtask

    initial begin
        int c;
        int rep_ofs[6] = '{3, 17, 20, 23, 26, 29};
        int rst_ofs[3] = '{3, 17, 20};

        RESETn = 1'b0;
        iBtnN  = 4'hF;
        model_reset();
        tick(3);
        RESETn = 1'b1;
        tick(2);
        check_reset_vals("reset");

        // auto-repeat; release lands on the expiry cycle, release wins
        c = cyc;
        iBtnN[1] = 1'b0;
        foreach (rep_ofs[i]) begin
            apply(1);
            expect_at(c + rep_ofs[i]);
        end
        tick(29);
        iBtnN[1] = 1'b1;
        tick(2);
        chk("repeat_busy_before_idle", int'(oBusy), 1);
        tick(1);
        chk("repeat_idle_after_release", int'(oBusy), 0);
        chk("repeat_ftw", int'(oFtw), 106);
        tick(5);

        // simultaneous btn1 + btn2
        c = cyc;
        iBtnN = 4'b1001;
        apply(1);
        expect_at(c + 3);
        tick(2);
        iBtnN = 4'hF;
        tick(10);
        chk("simul_ftw", int'(oFtw), 107);
        chk("simul_busy", int'(oBusy), 0);

        // wave select with wrap, held 20 cycles each
        for (int k = 0; k < 4; k++) begin
            c = cyc;
            iBtnN[0] = 1'b0;
            apply(0);
            expect_at(c + 3);
            tick(20);
            iBtnN[0] = 1'b1;
            tick(2);
            chk("wave_waitrel_busy", int'(oBusy), 1);
            tick(1);
            chk("wave_release_idle", int'(oBusy), 0);
            chk("wave_value", int'(oWave), (k + 1) % 4);
            tick(6);
        end

        // asynchronous reset in the middle of REPEAT
        c = cyc;
        iBtnN[1] = 1'b0;
        foreach (rst_ofs[i]) begin
            apply(1);
            expect_at(c + rst_ofs[i]);
        end
        tick(21);
        #2;
        RESETn = 1'b0;
        #1;
        check_reset_vals("midreset");
        chk("midreset_sb_drained", q.size(), 0);
        iBtnN = 4'hF;
        model_reset();
        tick(2);
        RESETn = 1'b1;
        tick(3);

        // saturation
        press(3);
        chk("sat_stepsel", int'(oStepSel), 1);
        for (int i = 0; i < 6; i++) press(1);
        chk("sat_ftw_196", int'(oFtw), 196);
        for (int i = 0; i < 3; i++) press(3);
        press(2);
        chk("sat_ftw_195", int'(oFtw), 195);
        press(3);
        press(1);
        chk("sat_ftw_max", int'(oFtw), 200);
        press(1);
        chk("sat_ftw_max_again", int'(oFtw), 200);
        for (int i = 0; i < 11; i++) press(2);
        for (int i = 0; i < 3; i++) press(3);
        for (int i = 0; i < 14; i++) press(2);
        chk("sat_ftw_10", int'(oFtw), 10);
        press(3);
        press(2);
        chk("sat_ftw_min", int'(oFtw), 0);
        press(2);
        chk("sat_ftw_min_again", int'(oFtw), 0);

        // bounce on btn0
        c = cyc;
        iBtnN[0] = 1'b0;
        apply(0);
        expect_at(c + 3);
        tick(1);
        iBtnN[0] = 1'b1;
        tick(1);
        iBtnN[0] = 1'b0;
        tick(1);
        iBtnN[0] = 1'b1;
        tick(3);
        chk("bounce_lock_busy", int'(oBusy), 1);
        tick(1);
        chk("bounce_idle", int'(oBusy), 0);
        tick(10);
        chk("bounce_wave", int'(oWave), 1);

        tick(5);
        chk("sb_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
